// File: rtl/flappy_bird_pkg.sv
// Shared constants and types for the flappy-bird video path.
// The renderer's parameter defaults are taken from here.
package flappy_bird_pkg;

  localparam int COORD_W     = 11;
  localparam int BIRD_W      = 16;
  localparam int BIRD_H      = 13;
  localparam int BIRD_ROM_AW = 8;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  // One pixel's worth of control carried between pipeline stages.
  typedef struct packed {
    logic valid;
    logic obstacle;
    logic in_box;
    logic frame_start;
  } stage_t;

endpackage

// File: rtl/bird_sprite_renderer_if.sv
// Pixel-stream, sprite-ROM and collision signals of the bird renderer.
// pix_valid qualifies pix_x/pix_y/obstacle_in in the cycle it is high; there is no
// ready because the stage never stalls, and pix_valid_o qualifies the outputs 2 cycles later.
interface bird_sprite_renderer_if;
  import flappy_bird_pkg::*;

  logic                   frame_start;
  logic [COORD_W-1:0]     bird_x;
  logic [COORD_W-1:0]     bird_y;
  logic                   pix_valid;
  logic [COORD_W-1:0]     pix_x;
  logic [COORD_W-1:0]     pix_y;
  logic                   obstacle_in;
  logic [BIRD_ROM_AW-1:0] rom_ad;
  logic                   rom_dout;
  logic                   pix_valid_o;
  logic                   bird_px_o;
  logic                   obstacle_o;
  logic                   collision_o;

  modport master (
    output frame_start, bird_x, bird_y, pix_valid, pix_x, pix_y, obstacle_in, rom_dout,
    input  rom_ad, pix_valid_o, bird_px_o, obstacle_o, collision_o
  );

  modport slave (
    input  frame_start, bird_x, bird_y, pix_valid, pix_x, pix_y, obstacle_in, rom_dout,
    output rom_ad, pix_valid_o, bird_px_o, obstacle_o, collision_o
  );

endinterface

// File: rtl/bird_sprite_renderer.sv
// Two-stage raster renderer for the bird sprite: box test + ROM address, then ROM bit,
// plus a per-frame sticky bird/obstacle overlap reported once per frame.
module bird_sprite_renderer #(
  parameter int COORD_W  = flappy_bird_pkg::COORD_W,
  parameter int SPRITE_W = flappy_bird_pkg::BIRD_W,
  parameter int SPRITE_H = flappy_bird_pkg::BIRD_H,
  parameter int ADDR_W   = flappy_bird_pkg::BIRD_ROM_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  bird_sprite_renderer_if.slave bus
);

  localparam int XW = $clog2(SPRITE_W);
  localparam logic [COORD_W-1:0] SW = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] SH = COORD_W'(SPRITE_H);

  logic [COORD_W-1:0]        act_x;
  logic [COORD_W-1:0]        act_y;
  logic                      armed;
  logic signed [COORD_W:0]   rel_x;
  logic signed [COORD_W:0]   rel_y;
  logic                      in_box;
  logic [ADDR_W-1:0]         addr;
  flappy_bird_pkg::stage_t   s1;
  logic                      frame_start_d2;
  logic                      hit;
  logic                      hit_flag;

  // One extra sign bit so a bird partly off the right/bottom edge never wraps to x/y=0.
  always_comb begin
    rel_x  = $signed({1'b0, bus.pix_x}) - $signed({1'b0, act_x});
    rel_y  = $signed({1'b0, bus.pix_y}) - $signed({1'b0, act_y});
    in_box = armed & bus.pix_valid
           & ~rel_x[COORD_W] & (rel_x[COORD_W-1:0] < SW)
           & ~rel_y[COORD_W] & (rel_y[COORD_W-1:0] < SH);
    addr   = '0;
    if (in_box)
      addr = (ADDR_W'(rel_y[COORD_W-1:0]) << XW) | ADDR_W'(rel_x[XW-1:0]);
  end

  assign hit = bus.pix_valid_o & bus.bird_px_o & bus.obstacle_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_x           <= '0;
      act_y           <= '0;
      armed           <= 1'b0;
      bus.rom_ad      <= '0;
      s1              <= '0;
      bus.pix_valid_o <= 1'b0;
      bus.obstacle_o  <= 1'b0;
      bus.bird_px_o   <= 1'b0;
      frame_start_d2  <= 1'b0;
      bus.collision_o <= 1'b0;
      hit_flag        <= 1'b0;
    end else begin
      // The pixel sharing this cycle with frame_start was already tested against the old box.
      if (bus.frame_start) begin
        act_x <= bus.bird_x;
        act_y <= bus.bird_y;
        armed <= 1'b1;
      end

      bus.rom_ad <= addr;
      s1 <= '{valid:       bus.pix_valid,
              obstacle:    bus.pix_valid & bus.obstacle_in,
              in_box:      in_box,
              frame_start: bus.frame_start};

      bus.pix_valid_o <= s1.valid;
      bus.obstacle_o  <= s1.obstacle;
      bus.bird_px_o   <= s1.in_box & bus.rom_dout;
      frame_start_d2  <= s1.frame_start;

      // The hit visible alongside frame_start_d2 still belongs to the frame that is ending.
      if (frame_start_d2) begin
        bus.collision_o <= hit_flag | hit;
        hit_flag        <= 1'b0;
      end else begin
        bus.collision_o <= 1'b0;
        hit_flag        <= hit_flag | hit;
      end
    end
  end

endmodule

// File: tb/tb_bird_sprite_renderer.sv
// Bench for bird_sprite_renderer: random sprite ROM model, directed raster windows and a
// randomized phase, all compared against an arithmetic per-pixel model.
module tb_bird_sprite_renderer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bird_sprite_renderer_if bus();

  bird_sprite_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic rom_mem [0:255];
  assign bus.rom_dout = rom_mem[bus.rom_ad];

  // Reference model state
  logic [10:0] m_ax, m_ay;
  logic        m_armed, m_flag;

  logic [7:0] exp_ad_q[$];
  logic [2:0] exp_s2_q[$];
  logic [0:0] exp_col_q[$];
  int         cx_q[$], cy_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int bird_cnt, coll_cnt, max_ad, box_x0, box_y0;
  logic chk_box = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_ax = '0; m_ay = '0; m_armed = 1'b0; m_flag = 1'b0;
    exp_ad_q = {};
    exp_s2_q = {3'b000};
    exp_col_q = {1'b0, 1'b0};
    cx_q = {0};
    cy_q = {0};
  endtask

  task automatic step(input logic fs, input logic [10:0] bx, input logic [10:0] by,
                      input logic pv, input logic [10:0] px, input logic [10:0] py,
                      input logic ob);
    int rx, ry, ad, x, y;
    logic inb, bird, h, c;
    bus.frame_start = fs; bus.bird_x = bx; bus.bird_y = by;
    bus.pix_valid = pv; bus.pix_x = px; bus.pix_y = py; bus.obstacle_in = ob;
    rx  = int'(px) - int'(m_ax);
    ry  = int'(py) - int'(m_ay);
    inb = m_armed && pv && rx >= 0 && rx < 16 && ry >= 0 && ry < 13;
    ad  = inb ? ry * 16 + rx : 0;
    bird = inb && rom_mem[ad];
    h = pv && bird && ob;
    if (fs) begin
      c = m_flag | h; m_flag = 1'b0;
      m_ax = bx; m_ay = by; m_armed = 1'b1;
    end else begin
      c = 1'b0; m_flag = m_flag | h;
    end
    exp_ad_q.push_back(8'(ad));
    exp_s2_q.push_back({pv, bird, pv & ob});
    exp_col_q.push_back(c);
    cx_q.push_back(int'(px));
    cy_q.push_back(int'(py));
    @(posedge clk); #1;
    check("rom_ad", 32'(bus.rom_ad), 32'(exp_ad_q.pop_front()));
    check("stage2", 32'({bus.pix_valid_o, bus.bird_px_o, bus.obstacle_o}), 32'(exp_s2_q.pop_front()));
    check("collision", 32'(bus.collision_o), 32'(exp_col_q.pop_front()));
    x = cx_q.pop_front();
    y = cy_q.pop_front();
    if (int'(bus.rom_ad) > max_ad) max_ad = int'(bus.rom_ad);
    if (bus.bird_px_o) bird_cnt++;
    if (bus.collision_o) coll_cnt++;
    if (chk_box && bus.bird_px_o)
      check("in_box", 32'(x >= box_x0 && x < box_x0 + 16 && y >= box_y0 && y < box_y0 + 13), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input int ob_lo, input int ob_hi);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        step(1'b0, '0, '0, 1'b1, 11'(x), 11'(y), (x >= ob_lo && x <= ob_hi));
  endtask

  task automatic do_reset();
    bus.pix_valid = 1'b1; bus.pix_x = 11'd103; bus.pix_y = 11'd205;
    bus.obstacle_in = 1'b1; bus.frame_start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rom_ad", 32'(bus.rom_ad), 32'd0);
    check("rst_valid", 32'(bus.pix_valid_o), 32'd0);
    check("rst_bird", 32'(bus.bird_px_o), 32'd0);
    check("rst_obst", 32'(bus.obstacle_o), 32'd0);
    check("rst_coll", 32'(bus.collision_o), 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  function automatic int popcount_region(input int rows, input int cols);
    int n = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (rom_mem[r * 16 + c]) n++;
    return n;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = (i < 208) ? 1'($urandom_range(0, 1)) : 1'b0;
    rom_mem[6] = 1'b1;
    bus.frame_start = 1'b0; bus.bird_x = '0; bus.bird_y = '0;
    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.obstacle_in = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Unarmed: nothing drawn
    bird_cnt = 0; max_ad = 0;
    for (int i = 0; i < 60; i++)
      step(1'b0, 11'($urandom_range(0, 60)), 11'($urandom_range(0, 60)), 1'b1,
           11'($urandom_range(0, 80)), 11'($urandom_range(0, 80)), 1'($urandom_range(0, 1)));
    idle(2);
    check("unarmed_bird", 32'(bird_cnt), 32'd0);
    check("unarmed_ad", 32'(max_ad), 32'd0);

    // Single pixels around bird (100,200)
    step(1'b1, 11'd100, 11'd200, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 11'd103, 11'd205, 1'b0);
    check("ad_83", 32'(bus.rom_ad), 32'd83);
    step(1'b0, '0, '0, 1'b1, 11'd116, 11'd205, 1'b0);
    check("bird_83", 32'(bus.bird_px_o), 32'(rom_mem[83]));
    check("ad_x_out", 32'(bus.rom_ad), 32'd0);
    step(1'b0, '0, '0, 1'b1, 11'd103, 11'd213, 1'b0);
    check("ad_y_out", 32'(bus.rom_ad), 32'd0);
    idle(2);

    // Window around the bird: count of drawn pixels equals ROM popcount
    step(1'b1, 11'd100, 11'd200, 1'b0, '0, '0, 1'b0);
    idle(2);
    bird_cnt = 0; chk_box = 1'b1; box_x0 = 100; box_y0 = 200;
    scan(90, 130, 190, 220, -1, -1);
    idle(3);
    chk_box = 1'b0;
    check("popcount", 32'(bird_cnt), 32'(popcount_region(13, 16)));

    // Partial off-screen bird at (630,475)
    step(1'b1, 11'd630, 11'd475, 1'b0, '0, '0, 1'b0);
    idle(2);
    bird_cnt = 0; max_ad = 0; chk_box = 1'b1; box_x0 = 630; box_y0 = 475;
    scan(600, 639, 460, 479, -1, -1);
    scan(0, 20, 0, 5, -1, -1);
    idle(3);
    chk_box = 1'b0;
    check("partial_cnt", 32'(bird_cnt), 32'(popcount_region(5, 10)));
    check("partial_maxad", 32'(max_ad <= 73), 32'd1);

    // Obstacle columns 105..107 overlap the bird -> one pulse at the next frame
    step(1'b1, 11'd100, 11'd200, 1'b0, '0, '0, 1'b0);
    idle(2);
    coll_cnt = 0;
    scan(90, 130, 195, 215, 105, 107);
    step(1'b1, 11'd100, 11'd200, 1'b0, '0, '0, 1'b0);
    idle(5);
    check("coll_one", 32'(coll_cnt), 32'd1);

    // Obstacle at x=300 never touches the bird
    coll_cnt = 0;
    scan(90, 310, 198, 202, 300, 300);
    step(1'b1, 11'd100, 11'd200, 1'b0, '0, '0, 1'b0);
    idle(5);
    check("coll_none", 32'(coll_cnt), 32'd0);

    // frame_start coincident with a pixel uses the old position
    step(1'b1, 11'd0, 11'd0, 1'b1, 11'd103, 11'd205, 1'b0);
    check("fs_old_pos", 32'(bus.rom_ad), 32'd83);
    step(1'b0, '0, '0, 1'b1, 11'd103, 11'd205, 1'b0);
    check("fs_new_pos", 32'(bus.rom_ad), 32'd0);
    idle(2);

    // Randomized phase, back-to-back frame_starts, edge positions
    for (int i = 0; i < 3000; i++) begin
      logic fs;
      logic [10:0] bx, by, px, py;
      fs = ($urandom_range(0, 39) == 0) || ($urandom_range(0, 299) == 0);
      bx = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(2030, 2047)) : 11'($urandom_range(0, 60));
      by = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(2030, 2047)) : 11'($urandom_range(0, 60));
      px = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 80));
      py = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 80));
      step(fs, bx, by, 1'($urandom_range(0, 3) != 0), px, py, 1'($urandom_range(0, 2) == 0));
      if (i == 1500) do_reset();
    end
    idle(3);

    // Reset mid-frame clears armed
    step(1'b1, 11'd100, 11'd200, 1'b0, '0, '0, 1'b0);
    scan(100, 110, 202, 203, 100, 110);
    do_reset();
    step(1'b0, '0, '0, 1'b1, 11'd103, 11'd205, 1'b1);
    check("post_rst_ad", 32'(bus.rom_ad), 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
